// File: rtl/year_pkg.sv
// Shared constants and state encoding for the year entry and year calculation stages.
package year_pkg;

   localparam int K            = 13;
   localparam int MAX_DIGITS   = 4;
   localparam int YEAR_MAX     = (1 << (K - 1)) - 1;
   localparam int DEFAULT_YEAR = 2019;

   typedef enum logic [1:0] {
      IDLE   = 2'b00,
      ACCUM  = 2'b01,
      COMMIT = 2'b10
   } state_t;

endpackage

// File: rtl/year_entry_mac10.sv
// Combinational acc*10 + digit.
// The result is one bit wider than acc, so an oversized entry is caught before it is truncated.
module mac10
   import year_pkg::*;
#(
   parameter int W = K
) (
   input  logic [W-1:0] acc,
   input  logic [3:0]   digit,
   output logic [W:0]   result
);

   logic [W:0] acc_w;

   assign acc_w  = {1'b0, acc};
   assign result = (acc_w << 3) + (acc_w << 1) + {{(W - 3){1'b0}}, digit};

endmodule

// File: rtl/year_entry.sv
// Keypad year entry: accumulates BCD digits and a sign, then commits a K-bit signed year.
// Malformed and out-of-range keys are rejected with a one-cycle err pulse.
module year_entry
   import year_pkg::*;
(
   input  logic                clk,
   input  logic                reset,
   input  logic                digit_valid,
   input  logic [3:0]          digit,
   input  logic                neg_key,
   input  logic                clear_key,
   input  logic                enter_key,
   output logic signed [K-1:0] year_out,
   output logic                year_valid,
   output logic                ready,
   output logic [2:0]          digit_count,
   output logic                err
);

   localparam logic [K:0] LIMIT     = (K + 1)'(YEAR_MAX);
   localparam logic [2:0] MAX_COUNT = 3'(MAX_DIGITS);

   state_t       state;
   logic [K-1:0] acc;
   logic         neg;
   logic [K:0]   acc_next;
   logic         digit_ok;

   mac10 #(.W(K)) u_mac10 (
      .acc    (acc),
      .digit  (digit),
      .result (acc_next)
   );

   // The digit count is checked first: with at most MAX_DIGITS-1 digits held, acc*10+9 cannot exceed the K+1 bit result.
   assign digit_ok = (digit <= 4'd9) && (digit_count < MAX_COUNT) && (acc_next <= LIMIT);
   assign ready    = (state != COMMIT);

   // NOTE: every register here is sequential state, so all updates use non-blocking assignments.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state       <= IDLE;
         acc         <= '0;
         neg         <= 1'b0;
         digit_count <= '0;
         year_out    <= '0;
         year_valid  <= 1'b0;
         err         <= 1'b0;
      end else begin
         year_valid <= 1'b0;
         err        <= 1'b0;
         case (state)
            IDLE, ACCUM: begin
               if (clear_key) begin
                  acc         <= '0;
                  neg         <= 1'b0;
                  digit_count <= '0;
                  state       <= IDLE;
               end else if (enter_key) begin
                  if (state == ACCUM) state <= COMMIT;
                  else                err   <= 1'b1;
               end else if (neg_key) begin
                  neg <= ~neg;
               end else if (digit_valid) begin
                  if (digit_ok) begin
                     acc         <= acc_next[K-1:0];
                     digit_count <= digit_count + 3'd1;
                     state       <= ACCUM;
                  end else begin
                     err <= 1'b1;
                  end
               end
            end
            COMMIT: begin
               // Negating a zero magnitude yields zero, so -0 commits as 0.
               year_out    <= neg ? -acc : acc;
               year_valid  <= 1'b1;
               acc         <= '0;
               neg         <= 1'b0;
               digit_count <= '0;
               state       <= IDLE;
            end
            default: begin
               acc         <= '0;
               neg         <= 1'b0;
               digit_count <= '0;
               state       <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_year_entry.sv
// Directed bench for year_entry; committed years are checked against a queue of expected values.
module tb_year_entry;

   import year_pkg::*;

   logic                clk = 1'b0;
   logic                reset;
   logic                digit_valid;
   logic [3:0]          digit;
   logic                neg_key;
   logic                clear_key;
   logic                enter_key;
   logic signed [K-1:0] year_out;
   logic                year_valid;
   logic                ready;
   logic [2:0]          digit_count;
   logic                err;

   int          errors     = 0;
   int          checks     = 0;
   int          valid_seen = 0;
   logic [12:0] sb[$];

   year_entry dut (
      .clk         (clk),
      .reset       (reset),
      .digit_valid (digit_valid),
      .digit       (digit),
      .neg_key     (neg_key),
      .clear_key   (clear_key),
      .enter_key   (enter_key),
      .year_out    (year_out),
      .year_valid  (year_valid),
      .ready       (ready),
      .digit_count (digit_count),
      .err         (err)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] observed, input logic [31:0] expected);
      checks++;
      assert (observed === expected)
      else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, observed, expected);
      end
   endtask

   // Drive one cycle of keys at the falling edge; return #1 after the rising edge that samples them.
   task automatic keys(input logic dv, input logic [3:0] d, input logic nk, input logic ck, input logic ek);
      @(negedge clk);
      digit_valid = dv;
      digit       = d;
      neg_key     = nk;
      clear_key   = ck;
      enter_key   = ek;
      @(posedge clk);
      #1;
      digit_valid = 1'b0;
      digit       = 4'd0;
      neg_key     = 1'b0;
      clear_key   = 1'b0;
      enter_key   = 1'b0;
   endtask

   task automatic press_digit(input logic [3:0] d);
      keys(1'b1, d, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic idle();
      keys(1'b0, 4'd0, 1'b0, 1'b0, 1'b0);
   endtask

   // Scoreboard consumer: every valid pulse must match the oldest expected year.
   always @(negedge clk) begin
      if (reset === 1'b1 && year_valid === 1'b1) begin
         valid_seen++;
         check("valid_expected", {31'd0, sb.size() != 0}, 32'd1);
         if (sb.size() != 0) check("sb_year", {19'd0, year_out}, {19'd0, sb.pop_front()});
      end
   end

   initial begin
      reset       = 1'b0;
      digit_valid = 1'b0;
      digit       = 4'd0;
      neg_key     = 1'b0;
      clear_key   = 1'b0;
      enter_key   = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      check("rst_year_out", {19'd0, year_out}, 32'd0);
      check("rst_valid", {31'd0, year_valid}, 32'd0);
      check("rst_err", {31'd0, err}, 32'd0);
      check("rst_ready", {31'd0, ready}, 32'd1);
      check("rst_count", {29'd0, digit_count}, 32'd0);
      @(negedge clk);
      reset = 1'b1;

      // 2019
      press_digit(4'd2);
      check("cnt_1", {29'd0, digit_count}, 32'd1);
      press_digit(4'd0);
      press_digit(4'd1);
      press_digit(4'd9);
      check("cnt_4", {29'd0, digit_count}, 32'd4);
      sb.push_back(13'h07E3);
      keys(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("commit_ready", {31'd0, ready}, 32'd0);
      check("commit_no_valid_yet", {31'd0, year_valid}, 32'd0);
      idle();
      check("y2019_valid", {31'd0, year_valid}, 32'd1);
      check("y2019_value", {19'd0, year_out}, 32'h07E3);
      check("y2019_cnt", {29'd0, digit_count}, 32'd0);
      check("y2019_ready", {31'd0, ready}, 32'd1);
      idle();
      check("y2019_pulse_end", {31'd0, year_valid}, 32'd0);
      check("y2019_held", {19'd0, year_out}, 32'h07E3);

      // -45
      keys(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
      check("neg_no_err", {31'd0, err}, 32'd0);
      press_digit(4'd4);
      press_digit(4'd5);
      sb.push_back(13'h1FD3);
      keys(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      idle();
      check("m45_valid", {31'd0, year_valid}, 32'd1);
      check("m45_value", {19'd0, year_out}, 32'h1FD3);
      idle();

      // 409, then 6 would make 4096
      press_digit(4'd4);
      press_digit(4'd0);
      press_digit(4'd9);
      press_digit(4'd6);
      check("ovf_err", {31'd0, err}, 32'd1);
      check("ovf_cnt", {29'd0, digit_count}, 32'd3);
      sb.push_back(13'h0199);
      keys(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("ovf_enter_no_err", {31'd0, err}, 32'd0);
      idle();
      check("y409_valid", {31'd0, year_valid}, 32'd1);
      check("y409_value", {19'd0, year_out}, 32'h0199);
      idle();

      // fifth digit rejected
      press_digit(4'd1);
      press_digit(4'd2);
      press_digit(4'd3);
      press_digit(4'd4);
      press_digit(4'd5);
      check("fifth_err", {31'd0, err}, 32'd1);
      check("fifth_cnt", {29'd0, digit_count}, 32'd4);
      keys(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
      check("clear_cnt", {29'd0, digit_count}, 32'd0);

      // malformed digit and enter with no digits
      press_digit(4'hA);
      check("bad_digit_err", {31'd0, err}, 32'd1);
      check("bad_digit_cnt", {29'd0, digit_count}, 32'd0);
      keys(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("empty_enter_err", {31'd0, err}, 32'd1);
      check("empty_enter_ready", {31'd0, ready}, 32'd1);
      idle();
      check("empty_enter_no_valid", {31'd0, year_valid}, 32'd0);
      check("err_pulse_end", {31'd0, err}, 32'd0);

      // clear beats enter in the same cycle
      press_digit(4'd1);
      press_digit(4'd2);
      keys(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
      check("clr_ent_no_err", {31'd0, err}, 32'd0);
      check("clr_ent_cnt", {29'd0, digit_count}, 32'd0);
      check("clr_ent_ready", {31'd0, ready}, 32'd1);
      idle();
      check("clr_ent_no_valid", {31'd0, year_valid}, 32'd0);
      check("clr_ent_held", {19'd0, year_out}, 32'h0199);

      // reset during COMMIT aborts the entry
      press_digit(4'd7);
      press_digit(4'd7);
      keys(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
      check("abort_in_commit", {31'd0, ready}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("abort_year_out", {19'd0, year_out}, 32'd0);
      check("abort_valid", {31'd0, year_valid}, 32'd0);
      check("abort_ready", {31'd0, ready}, 32'd1);
      check("abort_cnt", {29'd0, digit_count}, 32'd0);
      check("abort_err", {31'd0, err}, 32'd0);
      @(posedge clk);
      #1;
      check("abort_held_low", {31'd0, year_valid}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      idle();
      idle();
      check("abort_after_release", {31'd0, year_valid}, 32'd0);

      check("valid_pulse_total", valid_seen, 32'd3);
      check("sb_drained", sb.size(), 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
